// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op-codes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD        = 3'b000;
  localparam logic [2:0] OP_SUB        = 3'b001;
  localparam logic [2:0] OP_MUL        = 3'b010;
  localparam logic [2:0] OP_DIV        = 3'b011;
  localparam logic [2:0] OP_LAST_LEGAL = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first asserted request after rr_last,
// wrapping modulo NUM_REQ. Grant is one-hot, or zero when nothing is requested.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IDX_W'((int'(rr_last) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters with
// round-robin grant, registered operands/result and an error qualifier.
//
//   state | meaning
//   IDLE  | arbitrate; grant one requester and latch its operands
//   EXEC  | latched operands on alu_*; capture result at the edge
//   RESP  | hold response toward owner until its rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 4,
  parameter int OP_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_result,
  output logic [7:0]                ops_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_last;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic [OP_W-1:0]    op_q;
  logic               req_hs;
  logic               rsp_hs;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [OP_W-1:0]    sel_op;
  logic               op_illegal;
  logic               div_zero;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .rr_last (rr_last),
    .grant   (win_gnt),
    .idx     (win_idx)
  );

  assign sel_a  = req_a[int'(win_idx)*DATA_W +: DATA_W];
  assign sel_b  = req_b[int'(win_idx)*DATA_W +: DATA_W];
  assign sel_op = req_op[int'(win_idx)*OP_W +: OP_W];

  assign op_illegal = op_q > OP_W'(OP_LAST_LEGAL);
  assign div_zero   = (op_q == OP_W'(OP_DIV)) && (alu_b == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    req_hs    = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = win_gnt;
        if (|win_gnt) begin
          req_hs    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // alu_* double as the operand latch, so they only move on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last    <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      op_q       <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      if (req_hs) begin
        owner  <= win_idx;
        op_q   <= sel_op;
        alu_a  <= sel_a;
        alu_b  <= sel_b;
        alu_op <= (sel_op > OP_W'(OP_LAST_LEGAL)) ? OP_W'(OP_ADD) : sel_op;
      end
      if (state == EXEC) begin
        if (op_illegal || div_zero) begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
        end else begin
          rsp_result <= alu_result;
          rsp_err    <= 1'b0;
        end
      end
      if (rsp_hs) begin
        rr_last  <= owner;
        ops_done <= ops_done + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// contention/backpressure/reset/wrap sequences, then randomized traffic.
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int DW = 4;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*OW-1:0] req_op;
  logic [DW-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic          rsp_err;
  logic [OW-1:0] alu_op;
  logic [7:0]    ops_done;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .ops_done(ops_done)
  );

  // External ALU stand-in; garbage on div-by-zero so masking is visible.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a * alu_b;
      3'd3:    alu_result = (alu_b == 0) ? 4'hF : alu_a / alu_b;
      default: alu_result = 4'h5;
    endcase
  end

  function automatic logic [4:0] ref_op(input int a, input int b, input int op);
    int r;
    r = 0;
    if (op > 3 || (op == 3 && b == 0)) return 5'h10;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      default: r = a / b;
    endcase
    return {1'b0, r[3:0]};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
    req_a[r*DW +: DW]  = a;
    req_b[r*DW +: DW]  = b;
    req_op[r*OW +: OW] = op;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_result"}, rsp_result, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_alu_a"}, alu_a, 0);
    chk({nm, "_alu_b"}, alu_b, 0);
    chk({nm, "_alu_op"}, alu_op, 0);
    chk({nm, "_ops_done"}, ops_done, 0);
  endtask

  task automatic single(input int r, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [3:0] res, input logic err,
                        input string nm);
    logic [N-1:0] m;
    m = '0; m[r] = 1'b1;
    @(negedge clk);
    set_req(r, a, b, op); req_valid = m; rsp_ready = '0;
    #1 chk({nm, "_ready"}, req_ready, m);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk({nm, "_exec_valid"}, rsp_valid, 0);
    chk({nm, "_alu_a"}, alu_a, a);
    chk({nm, "_alu_b"}, alu_b, b);
    chk({nm, "_alu_op"}, alu_op, (op > 3'd3) ? 3'd0 : op);
    @(negedge clk);
    rsp_ready = m;
    #1;
    chk({nm, "_rsp_valid"}, rsp_valid, m);
    chk({nm, "_result"}, rsp_result, res);
    chk({nm, "_err"}, rsp_err, err);
    @(negedge clk);
    rsp_ready = '0; exp_ops++;
    #1;
    chk({nm, "_after_valid"}, rsp_valid, 0);
    chk({nm, "_ops_done"}, ops_done, exp_ops & 255);
  endtask

  task automatic wait_rsp(input logic [N-1:0] m, input logic [3:0] res, input logic err,
                          input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      rsp_ready = m;
      #1;
      if (rsp_valid != 0) seen = 1'b1;
    end
    chk({nm, "_valid"}, rsp_valid, m);
    chk({nm, "_result"}, rsp_result, res);
    chk({nm, "_err"}, rsp_err, err);
    @(negedge clk);
    rsp_ready = '0;
    if (seen) exp_ops++;
  endtask

  typedef struct {
    int         r;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic       err;
  } vec_t;

  vec_t vecs[9];

  // random-phase model state
  bit         pend[N];
  bit         outst;
  int         last_m, own, gcyc, dcyc, w, done;
  logic [3:0] ea, eb, er;
  logic [2:0] eop;
  logic       ee;
  logic [4:0] rv;
  logic [N-1:0] exp_rv, exp_rr;

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    req_a = '0; req_b = '0; req_op = '0;

    vecs[0] = '{0, 4'd3,  4'd4,  3'd0, 4'd7,  1'b0};
    vecs[1] = '{0, 4'd9,  4'd8,  3'd0, 4'd1,  1'b0};
    vecs[2] = '{1, 4'd2,  4'd5,  3'd1, 4'd13, 1'b0};
    vecs[3] = '{0, 4'd5,  4'd6,  3'd2, 4'd14, 1'b0};
    vecs[4] = '{1, 4'd13, 4'd4,  3'd3, 4'd3,  1'b0};
    vecs[5] = '{0, 4'd7,  4'd0,  3'd3, 4'd0,  1'b1};
    vecs[6] = '{1, 4'd1,  4'd1,  3'd5, 4'd0,  1'b1};
    vecs[7] = '{1, 4'd15, 4'd15, 3'd2, 4'd1,  1'b0};
    vecs[8] = '{0, 4'd15, 4'd2,  3'd3, 4'd7,  1'b0};

    reset_dut();
    #1 chk_reset("reset");

    foreach (vecs[i])
      single(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].err,
             $sformatf("vec%0d", i));

    // contention: both held valid, grants must alternate starting at 0
    reset_dut();
    set_req(0, 4'd1, 4'd2, 3'd0);
    set_req(1, 4'd5, 4'd1, 3'd1);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      logic [N-1:0] m;
      m = '0; m[n % 2] = 1'b1;
      #1 chk($sformatf("cont_grant%0d", n), req_ready, m);
      wait_rsp(m, (n % 2 == 0) ? 4'd3 : 4'd4, 1'b0, $sformatf("cont_rsp%0d", n));
    end
    req_valid = '0;
    #1 chk("cont_ops_done", ops_done, exp_ops);

    // backpressure on owner 1 while requester 0 waits and acks as non-owner
    @(negedge clk);
    set_req(1, 4'd6, 4'd3, 3'd2);
    set_req(0, 4'd0, 4'd0, 3'd0);
    req_valid = 2'b10; rsp_ready = 2'b01;
    #1 chk("bp_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b01;
    #1 chk("bp_exec_ready", req_ready, 0);
    @(negedge clk);
    #1;
    chk("bp_first_valid", rsp_valid, 2'b10);
    chk("bp_first_result", rsp_result, 4'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp_hold_valid%0d", k), rsp_valid, 2'b10);
      chk($sformatf("bp_hold_result%0d", k), rsp_result, 4'd2);
      chk($sformatf("bp_hold_err%0d", k), rsp_err, 1'b0);
      chk($sformatf("bp_hold_ready%0d", k), req_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 2'b10;
    #1 chk("bp_release_valid", rsp_valid, 2'b10);
    @(negedge clk);
    rsp_ready = '0; exp_ops++;
    #1;
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(2'b01, 4'd0, 1'b0, "bp_next");
    #1 chk("bp_ops_done", ops_done, exp_ops);

    // reset while a response is pending: dropped, no delivery
    @(negedge clk);
    set_req(0, 4'd9, 4'd9, 3'd0);
    req_valid = 2'b01; rsp_ready = '0;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1 chk("rst_pre_resp", rsp_valid, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 chk_reset("rst_mid");
    rsp_ready = 2'b01; rst = 1'b0; exp_ops = 0;
    @(negedge clk);
    #1;
    chk("rst_no_rsp", rsp_valid, 0);
    chk("rst_no_count", ops_done, 0);
    rsp_ready = '0;

    // 256 completions wrap the counter back to 0
    set_req(0, 4'd1, 4'd1, 3'd0);
    req_valid = 2'b01; rsp_ready = 2'b01;
    done = 0;
    for (int k = 0; k < 1000 && done < 256; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid[0]) begin
        chk("wrap_count", ops_done, done & 255);
        done++;
      end
    end
    @(negedge clk);
    req_valid = '0; rsp_ready = '0;
    #1;
    chk("wrap_done", done, 256);
    chk("wrap_zero", ops_done, 0);

    // randomized traffic against a transaction-level model
    reset_dut();
    last_m = N - 1; outst = 1'b0; dcyc = -10; gcyc = 0; own = 0;
    ea = '0; eb = '0; eop = '0; er = '0; ee = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(0, 9) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom),
                  3'($urandom_range(0, 7)));
        end
        req_valid[i] = pend[i];
        rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      #1;
      chk("rnd_ops_done", ops_done, exp_ops & 255);
      exp_rv = '0;
      if (outst && cyc >= gcyc + 2) exp_rv[own] = 1'b1;
      chk("rnd_rsp_valid", rsp_valid, exp_rv);
      if (outst && cyc == gcyc + 1) begin
        chk("rnd_alu_a", alu_a, ea);
        chk("rnd_alu_b", alu_b, eb);
        chk("rnd_alu_op", alu_op, (eop > 3'd3) ? 3'd0 : eop);
      end
      if (exp_rv != 0) begin
        chk("rnd_result", rsp_result, er);
        chk("rnd_err", rsp_err, ee);
        if (rsp_ready[own]) begin
          outst = 1'b0; exp_ops++; last_m = own; dcyc = cyc;
        end
      end
      exp_rr = '0;
      w = -1;
      if (!outst && cyc >= dcyc + 1) begin
        w = rr_pick(req_valid, last_m);
        if (w >= 0) exp_rr[w] = 1'b1;
      end
      chk("rnd_req_ready", req_ready, exp_rr);
      if (w >= 0) begin
        outst = 1'b1; gcyc = cyc; own = w;
        ea  = req_a[w*DW +: DW];
        eb  = req_b[w*DW +: DW];
        eop = req_op[w*OW +: OW];
        rv  = ref_op(int'(ea), int'(eb), int'(eop));
        ee  = rv[4];
        er  = rv[3:0];
        pend[w] = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
